// File: rtl/i2c_pad_conditioner_if.sv
// Signal bundle between the I2C_0 pad conditioner and its environment.
// master drives the raw pads and core OE lines; slave is the conditioner itself.
interface i2c_pad_conditioner_if;
  logic scl_pad_i;
  logic sda_pad_i;
  logic scl_oe_i;
  logic sda_oe_i;
  logic scl_o;
  logic sda_o;
  logic start_o;
  logic stop_o;
  logic bus_busy_o;
  logic arb_lost_o;
  logic stuck_o;

  modport master (
    output scl_pad_i, sda_pad_i, scl_oe_i, sda_oe_i,
    input  scl_o, sda_o, start_o, stop_o, bus_busy_o, arb_lost_o, stuck_o
  );

  modport slave (
    input  scl_pad_i, sda_pad_i, scl_oe_i, sda_oe_i,
    output scl_o, sda_o, start_o, stop_o, bus_busy_o, arb_lost_o, stuck_o
  );
endinterface

// File: rtl/i2c_pad_conditioner.sv
// Synchronise and deglitch the I2C_0 pads, detect START/STOP, track bus busy, flag lost arbitration.
// Define I2C_PAD_COND_TIMEOUT_EN to add the SCL-held-low timeout (stuck_o).
module i2c_pad_conditioner #(
  parameter int unsigned FILT_LEN    = 5,
  parameter int unsigned TIMEOUT_CYC = 1750000
) (
  input  logic                   clk_riscv,
  input  logic                   rst_in,
  i2c_pad_conditioner_if.slave   bus
);

  localparam int unsigned      CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Index 0 is SCL, index 1 is SDA throughout.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [CW-1:0] cnt [2];
  logic          scl_q;
  logic          sda_q;
  logic          start_cond;
  logic          stop_cond;
  logic          arb_cond;
  logic          start_q;
  logic          stop_q;
  logic          arb_q;
  logic          stuck;
  logic          stuck_rise;
  logic          bus_busy;
  logic          unused_scl_oe;
  state_t        state_q;
  state_t        state_d;

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= {bus.sda_pad_i, bus.scl_pad_i};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A line changing in the same cycle as the other one disqualifies START/STOP.
  assign start_cond = sda_q & ~filt[1] & scl_q & filt[0];
  assign stop_cond  = ~sda_q & filt[1] & scl_q & filt[0];
  assign arb_cond   = (state_q == BUSY) & ~scl_q & filt[0] & ~bus.sda_oe_i & ~filt[1];

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      arb_q   <= 1'b0;
    end else begin
      scl_q   <= filt[0];
      sda_q   <= filt[1];
      start_q <= start_cond;
      stop_q  <= stop_cond;
      arb_q   <= arb_cond;
    end
  end

`ifdef I2C_PAD_COND_TIMEOUT_EN
  localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYC);

  logic [31:0] to_cnt;
  logic        stuck_q;

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      to_cnt  <= '0;
      stuck_q <= 1'b0;
    end else begin
      if (filt[0]) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 32'd1;
      end
      stuck_q <= stuck;
    end
  end

  assign stuck      = (to_cnt == TO_MAX);
  assign stuck_rise = stuck & ~stuck_q;
`else
  logic unused_timeout;

  assign stuck          = 1'b0;
  assign stuck_rise     = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Repeated START and stray STOP leave the state alone; only the pulses report them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_cond) state_d = BUSY;
      BUSY: if (stuck_rise || stop_cond) state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_busy = (state_q == BUSY);
  end

  // The core's SCL drive is carried on the bundle but nothing here depends on it.
  assign unused_scl_oe  = bus.scl_oe_i;

  assign bus.scl_o      = filt[0];
  assign bus.sda_o      = filt[1];
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.arb_lost_o = arb_q;
  assign bus.bus_busy_o = bus_busy;
  assign bus.stuck_o    = stuck;

endmodule
